// File: rtl/ecg_moving_avg.sv
// Boxcar moving average over the last 2**LOG2_TAPS ECG samples, using a running sum and a circular buffer.
// Optional build macro MA_WARMUP_SUPPRESS_EN holds off o_dout_dv until the window has filled once.

module ecg_moving_avg #(
    parameter int LOG2_TAPS = 3,
    parameter int DW        = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] i_din,
    input  logic          i_din_dv,
    output logic [DW-1:0] o_dout,
    output logic          o_dout_dv,
    output logic          o_drop
);

    // state | meaning
    // IDLE  | waiting for a rising edge on i_din_dv
    // UPD   | fold captured sample into running sum, overwrite oldest slot
    // OUT   | publish sum >> LOG2_TAPS and pulse o_dout_dv
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UPD  = 2'd1,
        OUT  = 2'd2
    } state_t;

    localparam int N  = 1 << LOG2_TAPS;
    localparam int SW = DW + LOG2_TAPS;

    state_t                r_state;
    logic [DW-1:0]         r_buf [N];
    logic [LOG2_TAPS-1:0]  r_wr_ptr;
    logic [SW-1:0]         r_sum;
    logic [DW-1:0]         r_sample;
    logic                  r_dv_q;
    logic [DW-1:0]         r_dout;
    logic                  r_dout_dv;
    logic                  r_drop;

    logic                  w_edge;
    logic [DW-1:0]         w_oldest;
    logic [SW-1:0]         w_sum_next;
    logic [DW-1:0]         w_avg;

`ifdef MA_WARMUP_SUPPRESS_EN
    localparam int FW = LOG2_TAPS + 1;
    logic [FW-1:0]         r_fill;
`endif

    assign w_edge     = i_din_dv & ~r_dv_q;
    assign w_oldest   = r_buf[r_wr_ptr];
    // Oldest sample is already part of r_sum, so the subtract cannot underflow.
    assign w_sum_next = r_sum + SW'(r_sample) - SW'(w_oldest);
    assign w_avg      = r_sum[SW-1:LOG2_TAPS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dv_q <= 1'b0;
        end else begin
            r_dv_q <= i_din_dv;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_wr_ptr  <= '0;
            r_sum     <= '0;
            r_sample  <= '0;
            r_dout    <= '0;
            r_dout_dv <= 1'b0;
            r_drop    <= 1'b0;
            for (int i = 0; i < N; i++) begin
                r_buf[i] <= '0;
            end
`ifdef MA_WARMUP_SUPPRESS_EN
            r_fill    <= '0;
`endif
        end else begin
            r_dout_dv <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_edge) begin
                        r_sample <= i_din;
                        r_state  <= UPD;
                    end
                end
                UPD: begin
                    if (w_edge) begin
                        r_drop <= 1'b1;
                    end
                    r_sum           <= w_sum_next;
                    r_buf[r_wr_ptr] <= r_sample;
                    r_wr_ptr        <= r_wr_ptr + 1'b1;
`ifdef MA_WARMUP_SUPPRESS_EN
                    if (r_fill != FW'(N)) begin
                        r_fill <= r_fill + 1'b1;
                    end
`endif
                    r_state <= OUT;
                end
                OUT: begin
                    if (w_edge) begin
                        r_drop <= 1'b1;
                    end
                    r_dout <= w_avg;
`ifdef MA_WARMUP_SUPPRESS_EN
                    r_dout_dv <= (r_fill == FW'(N));
`else
                    r_dout_dv <= 1'b1;
`endif
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_dout    = r_dout;
    assign o_dout_dv = r_dout_dv;
    assign o_drop    = r_drop;

endmodule

// File: doc/ecg_moving_avg.md
# ecg_moving_avg

Boxcar moving-average filter for ECG samples, sitting directly downstream of the MCP3202 SPI sampler. It consumes each 12-bit sample flagged by the sampler's data-valid output and produces the truncated mean of the last 2^LOG2_TAPS samples. A circular sample buffer and a running sum keep the cost at one add and one subtract per sample. It also suppresses high-frequency noise before the sample stream leaves the FPGA.

## Interface
- LOG2_TAPS, 3, log2 of the averaging window (legal 1..6; window N = 2^LOG2_TAPS)
- DW, 12, sample width (matches the ADC word)

- clk  in  1  system clock, 10–200 MHz, rising edge
- rst_n  in  1  asynchronous, active-low reset
- din  in  DW  ADC sample, stable while din_dv high
- din_dv  in  1  sampler data-valid; level or pulse, only its rising edge is used
- dout  out  DW  filtered sample, held between updates
- dout_dv  out  1  one-cycle pulse, dout new this cycle
- drop  out  1  sticky flag: a sample edge arrived while the block was busy

## Operation
- One clock and one asynchronous active-low reset (rst_n); all state is reset asynchronously.
- Internal state:
  - buf[N], DW bits each
  - wr_ptr, LOG2_TAPS bits, wraps N-1 -> 0
  - sum, DW+LOG2_TAPS bits, cannot overflow
  - sample_r, DW bits
  - dv_q, previous din_dv
  - fill counter, used only under the macro
- Edge detect: edge = din_dv & ~dv_q. dv_q is updated every cycle. A level held high produces exactly one edge.
- FSM states: IDLE, UPD, OUT.
  - IDLE: on edge, sample_r <= din and go to UPD. Otherwise stay.
  - UPD: sum <= sum + sample_r - buf[wr_ptr]; buf[wr_ptr] <= sample_r; wr_ptr <= wr_ptr + 1; go to OUT.
  - OUT: dout <= sum >> LOG2_TAPS (truncation, no rounding); dout_dv <= 1, subject to the Configuration rule; go to IDLE.
- An edge detected in UPD or OUT is discarded and sets drop <= 1. drop clears only on reset.
- Before the buffer fills, empty slots count as zero.
- Arithmetic is unsigned. The subtract uses the full sum width, and the result is never negative because the oldest sample is already included in sum.

## Timing
- Reset values:
  - dout = 0, dout_dv = 0, drop = 0
  - sum = 0, wr_ptr = 0, all buf entries = 0
  - state = IDLE, dv_q = 0, fill = 0
- Latency: edge sampled at clock edge E0 -> sum updated at E1 -> dout/dout_dv registered at E2.
  - dout_dv is high for the cycle after E2 and deasserts at E3.
- Minimum spacing between accepted edges is 3 clocks. At 500 sps there are always thousands of clocks to spare.
- An edge at E1 or E2 of a previous sample is dropped and sets drop. An edge at E3 or later is accepted.
- Reset asserted mid-operation (UPD or OUT) aborts immediately. No dout_dv is issued for the aborted sample.
- dout holds its last value until the next OUT state.

## Configuration
- MA_WARMUP_SUPPRESS_EN:
  - Defined: a saturating fill counter counts completed updates. dout_dv stays 0 for the first N-1 samples after reset, so the first pulse comes with the N-th sample. dout still updates internally on every sample.
  - Undefined: dout_dv pulses for every accepted sample, including warm-up partial averages (zero-filled).

## Test plan
1. Warm-up, LOG2_TAPS=3, macro undefined: reset, then eight edges with din=2048.
   - Required: dout = 256, 512, 768, …, 2048; one dout_dv pulse each, 3 clocks after each edge.
   - With MA_WARMUP_SUPPRESS_EN defined: exactly one dout_dv pulse, on the 8th sample, dout = 2048.
2. Wrap-around: eight samples of 100, then eight of 900.
   - Required: second-phase outputs 200, 300, …, 900.
   - wr_ptr wraps cleanly; no glitch at the 9th sample.
3. Truncation: steady-state alternating 0/4095 for 16 samples.
   - Required: dout = 2047 on every output after the 8th.
4. Level-held valid: hold din_dv high for 10 clocks, din=1000, after reset.
   - Required: exactly one dout_dv pulse, dout = 125, drop = 0.
5. Busy drop: second rising edge of din_dv 1 clock after an accepted edge.
   - Required: only one update; drop = 1 and stays 1.
   - Next properly spaced sample is averaged normally.
6. Reset mid-op: assert rst_n=0 during UPD.
   - Required: dout = 0, dout_dv = 0, drop = 0, sum = 0 immediately.
   - Then sample 800 -> dout = 100 (macro undefined).
